// File: rtl/alarm_unit_if.sv
// Alarm unit bus: BCD time from clock_unit, alarm programming/controls, status back.
interface alarm_unit_if;
    logic [3:0] cur_sec_o, cur_sec_t, cur_min_o, cur_min_t, cur_hr_o, cur_hr_t;
    logic [3:0] al_min_i_o, al_min_i_t, al_hr_i_o, al_hr_i_t;
    logic       al_load, al_en, snooze, stop;
    logic [3:0] al_min_o, al_min_t, al_hr_o, al_hr_t;
    logic       alarm, snoozing, al_err;

    modport master (
        output cur_sec_o, cur_sec_t, cur_min_o, cur_min_t, cur_hr_o, cur_hr_t,
        output al_min_i_o, al_min_i_t, al_hr_i_o, al_hr_i_t,
        output al_load, al_en, snooze, stop,
        input  al_min_o, al_min_t, al_hr_o, al_hr_t,
        input  alarm, snoozing, al_err
    );

    modport slave (
        input  cur_sec_o, cur_sec_t, cur_min_o, cur_min_t, cur_hr_o, cur_hr_t,
        input  al_min_i_o, al_min_i_t, al_hr_i_o, al_hr_i_t,
        input  al_load, al_en, snooze, stop,
        output al_min_o, al_min_t, al_hr_o, al_hr_t,
        output alarm, snoozing, al_err
    );
endinterface

// File: rtl/alarm_unit.sv
// HH:MM alarm with ring timeout and snooze, ticked by changes of clock_unit's seconds digit.
// Optional snooze limit enabled by defining ALARM_SNOOZE_LIMIT_EN.
module alarm_unit #(
    parameter int SNOOZE_SEC = 300,
    parameter int RING_SEC   = 60,
    parameter int MAX_SNOOZE = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    alarm_unit_if.slave bus
);
    localparam int SW = $clog2(SNOOZE_SEC + 1);
    localparam int RW = $clog2(RING_SEC + 1);

    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

    state_t        state;
    logic [SW-1:0] snz_cnt;
    logic [RW-1:0] ring_cnt;
    logic [3:0]    prev_sec;
    logic          tick_valid;
    logic [3:0]    al_mo, al_mt, al_ho, al_ht;
    logic          alarm_q, snoozing_q, al_err_q;
    logic          tick, match, load_ok, snz_allow;

    assign bus.al_min_o = al_mo;
    assign bus.al_min_t = al_mt;
    assign bus.al_hr_o  = al_ho;
    assign bus.al_hr_t  = al_ht;
    assign bus.alarm    = alarm_q;
    assign bus.snoozing = snoozing_q;
    assign bus.al_err   = al_err_q;

    assign tick  = tick_valid && (bus.cur_sec_o != prev_sec);
    assign match = tick && bus.cur_sec_t == 4'd0 && bus.cur_sec_o == 4'd0 &&
                   bus.cur_min_t == al_mt && bus.cur_min_o == al_mo &&
                   bus.cur_hr_t == al_ht && bus.cur_hr_o == al_ho;

    // Hour limit 23: tens 0/1 take any ones digit, tens 2 only 0..3.
    assign load_ok = (bus.al_min_i_o <= 4'd9) && (bus.al_min_i_t <= 4'd5) &&
                     (bus.al_hr_i_o <= 4'd9) &&
                     ((bus.al_hr_i_t < 4'd2) || (bus.al_hr_i_t == 4'd2 && bus.al_hr_i_o <= 4'd3));

`ifdef ALARM_SNOOZE_LIMIT_EN
    localparam int NW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
    logic [NW-1:0] snz_num;

    assign snz_allow = (snz_num != NW'(MAX_SNOOZE));

    // Count is held at zero while idle, so every ring episode starts fresh.
    always_ff @(posedge clk) begin
        if (!rst_n || state == IDLE)
            snz_num <= '0;
        else if (state == RING && bus.al_en && !bus.stop && bus.snooze && snz_allow)
            snz_num <= snz_num + 1'b1;
    end
`else
    logic unused_cfg;
    assign unused_cfg = |MAX_SNOOZE;
    assign snz_allow  = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_sec   <= 4'd0;
            tick_valid <= 1'b0;
        end else begin
            prev_sec   <= bus.cur_sec_o;
            tick_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {al_ht, al_ho, al_mt, al_mo} <= '0;
            al_err_q <= 1'b0;
        end else begin
            al_err_q <= bus.al_load && !load_ok;
            if (bus.al_load && load_ok) begin
                al_ht <= bus.al_hr_i_t;
                al_ho <= bus.al_hr_i_o;
                al_mt <= bus.al_min_i_t;
                al_mo <= bus.al_min_i_o;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ring_cnt   <= '0;
            snz_cnt    <= '0;
            alarm_q    <= 1'b0;
            snoozing_q <= 1'b0;
        end else if (!bus.al_en) begin
            state      <= IDLE;
            alarm_q    <= 1'b0;
            snoozing_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (match) begin
                        state    <= RING;
                        ring_cnt <= '0;
                        alarm_q  <= 1'b1;
                    end
                end
                RING: begin
                    if (bus.stop) begin
                        state   <= IDLE;
                        alarm_q <= 1'b0;
                    end else if (bus.snooze && snz_allow) begin
                        state      <= SNOOZE;
                        snz_cnt    <= SW'(SNOOZE_SEC);
                        alarm_q    <= 1'b0;
                        snoozing_q <= 1'b1;
                    end else if (tick) begin
                        if (ring_cnt == RW'(RING_SEC - 1)) begin
                            state   <= IDLE;
                            alarm_q <= 1'b0;
                        end else begin
                            ring_cnt <= ring_cnt + 1'b1;
                        end
                    end
                end
                SNOOZE: begin
                    if (bus.stop) begin
                        state      <= IDLE;
                        snoozing_q <= 1'b0;
                    end else if (tick) begin
                        if (snz_cnt == SW'(1)) begin
                            state      <= RING;
                            ring_cnt   <= '0;
                            alarm_q    <= 1'b1;
                            snoozing_q <= 1'b0;
                        end else begin
                            snz_cnt <= snz_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    alarm_q    <= 1'b0;
                    snoozing_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alarm_unit.sv
// Bench for alarm_unit: load table, hand-written ring/stop/snooze/reset sequences,
// then random time/control traffic checked every cycle against a seconds-based model.
module tb_alarm_unit;
    localparam int SNZ  = 300;
    localparam int RNG  = 60;
    localparam int MAXS = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    alarm_unit_if bus();

    alarm_unit #(.SNOOZE_SEC(SNZ), .RING_SEC(RNG), .MAX_SNOOZE(MAXS)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int t_now = 0;

    // Model: alarm time in minutes since midnight, remaining ticks as plain counts.
    bit m_ring, m_snz, m_err, m_tv;
    int m_ring_left, m_snz_left, m_al, m_prev, m_snz_num;

    typedef struct {
        logic [3:0] ht, ho, mt, mo;
        bit         err;
        int         hhmm;
    } ld_vec_t;

    ld_vec_t lv[9];

    function automatic ld_vec_t mk(input int ht, ho, mt, mo, err, hhmm);
        ld_vec_t v;
        v.ht = 4'(ht); v.ho = 4'(ho); v.mt = 4'(mt); v.mo = 4'(mo);
        v.err = (err != 0);
        v.hhmm = hhmm;
        return v;
    endfunction

    function automatic int stored_min();
        return int'(bus.al_hr_t) * 600 + int'(bus.al_hr_o) * 60 +
               int'(bus.al_min_t) * 10 + int'(bus.al_min_o);
    endfunction

    task automatic drive_time(input int t);
        int hh, mm, ss;
        t_now = t % 86400;
        hh = t_now / 3600; mm = (t_now / 60) % 60; ss = t_now % 60;
        bus.cur_hr_t  = 4'(hh / 10); bus.cur_hr_o  = 4'(hh % 10);
        bus.cur_min_t = 4'(mm / 10); bus.cur_min_o = 4'(mm % 10);
        bus.cur_sec_t = 4'(ss / 10); bus.cur_sec_o = 4'(ss % 10);
    endtask

    task automatic set_load(input int ht, ho, mt, mo);
        bus.al_hr_i_t  = 4'(ht); bus.al_hr_i_o  = 4'(ho);
        bus.al_min_i_t = 4'(mt); bus.al_min_i_o = 4'(mo);
    endtask

    task automatic model_edge();
        bit tk, ok, allow;
        int hr;
        if (!rst_n) begin
            m_ring = 0; m_snz = 0; m_err = 0; m_tv = 0;
            m_prev = 0; m_al = 0; m_snz_num = 0;
            return;
        end
        tk = m_tv && ((t_now % 10) != m_prev);
`ifdef ALARM_SNOOZE_LIMIT_EN
        allow = (m_snz_num < MAXS);
`else
        allow = 1;
`endif
        if (!bus.al_en) begin
            m_ring = 0; m_snz = 0;
        end else if (m_ring) begin
            if (bus.stop) m_ring = 0;
            else if (bus.snooze && allow) begin
                m_ring = 0; m_snz = 1; m_snz_left = SNZ; m_snz_num++;
            end else if (tk) begin
                m_ring_left--;
                if (m_ring_left == 0) m_ring = 0;
            end
        end else if (m_snz) begin
            if (bus.stop) m_snz = 0;
            else if (tk) begin
                m_snz_left--;
                if (m_snz_left == 0) begin
                    m_snz = 0; m_ring = 1; m_ring_left = RNG;
                end
            end
        end else if (tk && (t_now % 60) == 0 && (t_now / 60) == m_al) begin
            m_ring = 1; m_ring_left = RNG;
        end
        if (!m_ring && !m_snz) m_snz_num = 0;
        m_err = 0;
        if (bus.al_load) begin
            hr = int'(bus.al_hr_i_t) * 10 + int'(bus.al_hr_i_o);
            ok = bus.al_min_i_o <= 9 && bus.al_min_i_t <= 5 && bus.al_hr_i_o <= 9 && hr <= 23;
            if (ok) m_al = hr * 60 + int'(bus.al_min_i_t) * 10 + int'(bus.al_min_i_o);
            else m_err = 1;
        end
        m_prev = t_now % 10;
        m_tv = 1;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        vectors++;
        if (bus.alarm !== m_ring || bus.snoozing !== m_snz || bus.al_err !== m_err ||
            stored_min() != m_al) begin
            miscompares++;
            $display("FAIL model t=%0d: alarm/snoozing/al_err/stored got %b/%b/%b/%0d want %b/%b/%b/%0d",
                     t_now, bus.alarm, bus.snoozing, bus.al_err, stored_min(),
                     m_ring, m_snz, m_err, m_al);
        end
    endtask

    task automatic expect_out(input string name, input bit a, input bit s);
        vectors++;
        if (bus.alarm !== a || bus.snoozing !== s) begin
            miscompares++;
            $display("FAIL %s: alarm=%b snoozing=%b, required %b %b", name, bus.alarm, bus.snoozing, a, s);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic step_sec(input int n);
        repeat (n) begin
            drive_time(t_now + 1);
            cyc();
        end
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
    endtask

    task automatic pulse_snooze();
        bus.snooze = 1'b1; cyc(); bus.snooze = 1'b0;
    endtask

    // Parks the clock at 06:29:59, then shows 06:30:00 so the alarm starts ringing.
    task automatic ring_at_0630();
        drive_time(6 * 3600 + 29 * 60 + 59); cyc();
        step_sec(1);
    endtask

    initial begin
        lv[0] = mk(0, 6, 3, 0, 0, 390);
        lv[1] = mk(2, 4, 0, 0, 1, 390);
        lv[2] = mk(1, 2, 6, 0, 1, 390);
        lv[3] = mk(2, 3, 5, 9, 0, 1439);
        lv[4] = mk(1, 10, 0, 0, 1, 1439);
        lv[5] = mk(1, 9, 5, 9, 0, 1199);
        lv[6] = mk(2, 0, 0, 10, 1, 1199);
        lv[7] = mk(0, 0, 0, 0, 0, 0);
        lv[8] = mk(0, 6, 3, 0, 0, 390);

        bus.al_load = 0; bus.al_en = 0; bus.snooze = 0; bus.stop = 0;
        set_load(0, 0, 0, 0);
        drive_time(0);
        rst_n = 0;
        cyc(); cyc();
        expect_out("reset_outputs", 0, 0);
        chk_int("reset_err", int'(bus.al_err), 0);
        chk_int("reset_stored", stored_min(), 0);
        rst_n = 1;

        foreach (lv[i]) begin
            set_load(lv[i].ht, lv[i].ho, lv[i].mt, lv[i].mo);
            bus.al_load = 1; cyc(); bus.al_load = 0;
            chk_int($sformatf("load%0d_err", i), int'(bus.al_err), int'(lv[i].err));
            chk_int($sformatf("load%0d_stored", i), stored_min(), lv[i].hhmm);
            cyc();
            chk_int($sformatf("load%0d_err_end", i), int'(bus.al_err), 0);
        end

        bus.al_en = 1;
        drive_time(6 * 3600 + 29 * 60 + 55); cyc();
        step_sec(4);
        expect_out("before_match", 0, 0);
        step_sec(1);
        expect_out("ring_on", 1, 0);
        step_sec(59);
        expect_out("ring_hold", 1, 0);
        step_sec(1);
        expect_out("ring_timeout", 0, 0);

        ring_at_0630();
        expect_out("ring2_on", 1, 0);
        step_sec(5);
        pulse_stop();
        expect_out("stop", 0, 0);
        step_sec(55);
        expect_out("no_retrigger", 0, 0);

        ring_at_0630();
        step_sec(10);
        pulse_snooze();
        expect_out("snooze_enter", 0, 1);
        step_sec(SNZ - 1);
        expect_out("snooze_hold", 0, 1);
        step_sec(1);
        expect_out("snooze_ring", 1, 0);
        pulse_stop();
        expect_out("snooze_stop", 0, 0);

        ring_at_0630();
        step_sec(3);
        bus.al_en = 0; cyc(); bus.al_en = 1;
        expect_out("disarm", 0, 0);

        ring_at_0630();
        pulse_snooze();
        step_sec(5);
        rst_n = 0;
        drive_time(5);
        cyc();
        expect_out("reset_in_snooze", 0, 0);
        chk_int("reset_in_snooze_stored", stored_min(), 0);
        rst_n = 1;
        cyc();
        expect_out("first_cycle_masked", 0, 0);
        step_sec(10);

        set_load(0, 6, 3, 0);
        bus.al_load = 1; cyc(); bus.al_load = 0;
        ring_at_0630();
        for (int k = 0; k < 3; k++) begin
            pulse_snooze();
            expect_out($sformatf("snooze%0d_accepted", k + 1), 0, 1);
            step_sec(SNZ);
            expect_out($sformatf("snooze%0d_ring", k + 1), 1, 0);
        end
        pulse_snooze();
`ifdef ALARM_SNOOZE_LIMIT_EN
        expect_out("snooze4_ignored", 1, 0);
`else
        expect_out("snooze4_accepted", 0, 1);
`endif
        pulse_stop();
        expect_out("final_stop", 0, 0);

        for (int i = 0; i < 20000; i++) begin
            int r, nt, m;
            r = $urandom_range(0, 99);
            bus.stop    = ($urandom_range(0, 199) == 0);
            bus.snooze  = ($urandom_range(0, 99) == 0);
            bus.al_en   = ($urandom_range(0, 499) != 0);
            rst_n       = ($urandom_range(0, 1999) != 0);
            bus.al_load = 0;
            if ($urandom_range(0, 299) == 0) begin
                bus.al_load = 1;
                if ($urandom_range(0, 3) != 0) begin
                    m = (t_now / 60 + int'($urandom_range(0, 2))) % 1440;
                    set_load((m / 60) / 10, (m / 60) % 10, (m % 60) / 10, (m % 60) % 10);
                end else begin
                    set_load($urandom_range(0, 15), $urandom_range(0, 15),
                             $urandom_range(0, 15), $urandom_range(0, 15));
                end
            end
            if (r < 70)      nt = t_now + 1;
            else if (r < 90) nt = t_now;
            else if (r < 95) nt = m_al * 60 + 86400 - int'($urandom_range(0, 2));
            else             nt = $urandom_range(0, 86399);
            drive_time(nt);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
